// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result_ascii_tx byte-stream transmitter.
package result_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SKIP,
    ST_SEND,
    ST_TERM,
    ST_DONE
  } result_tx_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // ceil(data_w * log10(2)) using a fixed-point approximation of log10(2).
  function automatic int unsigned min_digits(input int unsigned data_w);
    return (data_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per cycle.
// start_i loads bin_i; busy_o is high for DATA_W shift cycles; done_o is a
// one-cycle pulse after the last shift, with bcd_o stable until the next start.
module bin2bcd_dd
  import result_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_DIGITS = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  if (NUM_DIGITS < min_digits(DATA_W)) begin : g_digits_check
    $error("bin2bcd_dd: NUM_DIGITS too small for DATA_W");
  end

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start_i && !busy_q) begin
      shift_d = bin_i;
      bcd_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_ascii_tx.sv
// Binary result word -> ASCII decimal byte stream with terminator and done pulse.
// Build option: RESULT_ASCII_TX_ZERO_PAD_EN sends all NUM_DIGITS digits
// (leading zeros included) instead of suppressing leading zeros.
module result_ascii_tx
  import result_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_DIGITS = 20,
  parameter logic [7:0]  TERM_CHAR  = ASCII_LF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] result_data,
  input  logic              result_valid,
  output logic              result_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < min_digits(DATA_W)) begin : g_digits_check
    $error("result_ascii_tx: NUM_DIGITS too small for DATA_W");
  end

  result_tx_state_t        state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    conv_start;
  logic                    conv_busy;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [3:0]              cur_digit;

  bin2bcd_dd #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (conv_start),
    .bin_i   (result_data),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = bcd[4*i +: 4];
      end
    end
  end

`ifndef RESULT_ASCII_TX_ZERO_PAD_EN
  logic [IDX_W-1:0] msd_idx;

  // Highest nonzero digit wins; stays 0 for a zero value so one '0' is printed.
  always_comb begin
    msd_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        msd_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    conv_start   = 1'b0;
    result_ready = 1'b0;
    tx_valid     = 1'b0;
    tx_byte      = '0;
    tx_done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        result_ready = !conv_busy;
        if (result_valid && !conv_busy) begin
          conv_start = 1'b1;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
`ifdef RESULT_ASCII_TX_ZERO_PAD_EN
        idx_d   = IDX_W'(NUM_DIGITS - 1);
`else
        idx_d   = msd_idx;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_byte  = ASCII_ZERO + {4'b0000, cur_digit};
        if (tx_ready) begin
          if (idx_q == '0) begin
            state_d = ST_TERM;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      ST_TERM: begin
        tx_valid = 1'b1;
        tx_byte  = TERM_CHAR;
        if (tx_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Self-checking bench for result_ascii_tx (honours RESULT_ASCII_TX_ZERO_PAD_EN).
module tb_result_ascii_tx;

`ifdef RESULT_ASCII_TX_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int LATENCY = 66;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] result_data = '0;
  logic        result_valid = 1'b0;
  logic        result_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_done;

  always #5 clk = ~clk;

  result_ascii_tx #(
    .DATA_W     (64),
    .NUM_DIGITS (20),
    .TERM_CHAR  (8'h0A)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_xfer = 0;
  logic [7:0] exp_q[$];
  bit         hold_pend = 1'b0;
  logic [7:0] hold_byte = '0;
  bit         done_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: decimal text of v, optionally zero-padded, then LF.
  task automatic push_expected(input logic [63:0] v);
    logic [7:0] digs[$];
    logic [63:0] r;
    r = v;
    do begin
      digs.push_front(8'h30 + 8'(r % 64'd10));
      r = r / 64'd10;
    end while (r != 0);
    if (PAD) begin
      while (digs.size() < 20) digs.push_front(8'h30);
    end
    foreach (digs[i]) exp_q.push_back(digs[i]);
    exp_q.push_back(8'h0A);
  endtask

  // Scoreboard monitor: transfers, hold stability, done-pulse timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      done_exp  = 1'b0;
    end else begin
      check("tx_done timing", tx_done, done_exp);
      done_exp = 1'b0;
      if (hold_pend) begin
        check("hold tx_valid", tx_valid, 1);
        check("hold tx_byte", tx_byte, hold_byte);
      end
      hold_pend = tx_valid && !tx_ready;
      hold_byte = tx_byte;
      if (tx_valid && tx_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected byte: got %0h expected none", tx_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("tx_byte", tx_byte, e);
          if (e == 8'h0A) done_exp = 1'b1;
        end
      end
    end
  end

  task automatic run_one(input string name, input logic [63:0] val, input bit toggle, input int exp_len);
    int lat, vcyc, k, x0, t;
    bit seen, dn;
    logic [3:0] pat;
    pat = 4'b1001;
    t = 0;
    while (!result_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, " result_ready"}, result_ready, 1);
    tx_ready = 1'b1;
    result_data = val;
    result_valid = 1'b1;
    push_expected(val);
    x0 = n_xfer;
    @(posedge clk); #1;
    result_valid = 1'b0;
    check({name, " ready low after accept"}, result_ready, 0);
    seen = 0; dn = 0; lat = 0; vcyc = 0; k = 0;
    for (int c = 1; c <= 600 && !dn; c++) begin
      @(posedge clk); #1;
      if (tx_valid) begin
        if (!seen) begin
          seen = 1;
          lat = c;
        end
        vcyc++;
      end
      if (tx_done) dn = 1;
      if (toggle && tx_valid) begin
        tx_ready = pat[k % 4];
        k++;
      end else begin
        tx_ready = 1'b1;
      end
    end
    check({name, " latency"}, lat, LATENCY);
    check({name, " done seen"}, dn, 1);
    if (!toggle) check({name, " valid cycles"}, vcyc, exp_len);
    check({name, " byte count"}, n_xfer - x0, exp_len);
    check({name, " queue drained"}, exp_q.size(), 0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " done one-shot"}, tx_done, 0);
    check({name, " ready after done"}, result_ready, 1);
  endtask

  typedef struct {
    string       name;
    logic [63:0] val;
    bit          toggle;
    int          exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"zero",   64'd0,           1'b0, PAD ? 21 : 2};
    vecs[1] = '{"1234",   64'd1234,        1'b0, PAD ? 21 : 5};
    vecs[2] = '{"max",    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 21};
    vecs[3] = '{"907bp",  64'd907,         1'b1, PAD ? 21 : 4};
    vecs[4] = '{"nine",   64'd9,           1'b0, PAD ? 21 : 2};
    vecs[5] = '{"ten",    64'd10,          1'b0, PAD ? 21 : 3};
    vecs[6] = '{"1e6",    64'd1000000,     1'b0, PAD ? 21 : 8};

    #1;
    check("reset tx_valid", tx_valid, 0);
    check("reset tx_done", tx_done, 0);
    check("reset tx_byte", tx_byte, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset result_ready", result_ready, 1);
    check("post-reset tx_valid", tx_valid, 0);

    foreach (vecs[i]) run_one(vecs[i].name, vecs[i].val, vecs[i].toggle, vecs[i].exp_len);

    // Busy-ignore then reset during SEND.
    begin
      int t;
      tx_ready = 1'b0;
      result_data = 64'd555;
      result_valid = 1'b1;
      push_expected(64'd555);
      @(posedge clk); #1;
      result_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      result_data = 64'd777;
      result_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check("busy result_ready", result_ready, 0);
      end
      result_valid = 1'b0;
      t = 0;
      while (!tx_valid && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      check("555 tx_valid", tx_valid, 1);
      check("555 first byte", tx_byte, PAD ? 8'h30 : 8'h35);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("555 mid tx_valid", tx_valid, 1);
      rst_n = 1'b0;
      #1;
      check("async reset tx_valid", tx_valid, 0);
      check("async reset tx_done", tx_done, 0);
      check("async reset tx_byte", tx_byte, 0);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check("after reset result_ready", result_ready, 1);
        check("after reset tx_valid", tx_valid, 0);
        check("after reset tx_done", tx_done, 0);
      end
    end

    run_one("42", 64'd42, 1'b0, PAD ? 21 : 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
